// File: rtl/fft4_pkg.sv
// Shared types and helpers for the 4-point FFT sequencer with external memory.
package fft4_pkg;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned FRAME_N = 4;
   localparam int unsigned CNT_W   = $clog2(FRAME_N);

   typedef enum logic [2:0] {
      ST_LOAD     = 3'd0,
      ST_L_SETTLE = 3'd1,
      ST_STAGE_A  = 3'd2,
      ST_STAGE_B  = 3'd3,
      ST_H_SETTLE = 3'd4,
      ST_OUT      = 3'd5
   } state_e;

   typedef logic signed [DATA_W-1:0] sample_t;

   // One memory bank word set: {write_0_0, write_0_1, write_1_0, write_1_1}
   typedef struct packed {
      sample_t w00;
      sample_t w01;
      sample_t w10;
      sample_t w11;
   } bank_t;

   // Saturating add (sub=0) or subtract (sub=1), clamped to the sample range
   function automatic sample_t sat_addsub(input sample_t a, input sample_t b, input logic sub);
      logic signed [DATA_W:0] r;
      r = sub ? ((DATA_W+1)'(a) - (DATA_W+1)'(b)) : ((DATA_W+1)'(a) + (DATA_W+1)'(b));
      if (r[DATA_W] != r[DATA_W-1]) begin
         return r[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      end
      return r[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/fft4_bfly.sv
// Radix-2 butterfly: sum and difference of two samples.
// Overflow handling: define FFT4_SAT_EN to saturate, otherwise results wrap modulo 256.
module fft4_bfly
   import fft4_pkg::*;
(
   input  sample_t a,
   input  sample_t b,
   output sample_t sum_c,
   output sample_t diff_c
);

`ifdef FFT4_SAT_EN
   assign sum_c  = sat_addsub(a, b, 1'b0);
   assign diff_c = sat_addsub(a, b, 1'b1);
`else
   assign sum_c  = a + b;
   assign diff_c = a - b;
`endif

endmodule

// File: rtl/fft4_mem_seq.sv
// 4-point FFT sequencer staging samples and first-stage butterflies through an
// external two-bank memory. Build option FFT4_SAT_EN selects saturating arithmetic
// (applied inside fft4_bfly); default build wraps.
module fft4_mem_seq
   import fft4_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              mem_write_ctrl_s,
   output logic              mem_read_ctrl_s,
   output logic [DATA_W-1:0] write_0_0,
   output logic [DATA_W-1:0] write_0_1,
   output logic [DATA_W-1:0] write_1_0,
   output logic [DATA_W-1:0] write_1_1,
   input  logic [DATA_W-1:0] read_0_0,
   input  logic [DATA_W-1:0] read_0_1,
   input  logic [DATA_W-1:0] read_1_0,
   input  logic [DATA_W-1:0] read_1_1,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_re,
   output logic [DATA_W-1:0] m_im
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  beat_q, beat_d;
   bank_t             sh_l_q, sh_l_d;
   bank_t             sh_h_q, sh_h_d;
   bank_t             wr_q, wr_d;
   sample_t           x0_q, x0_d;
   sample_t           x1_q, x1_d;
   logic              s_ready_q, s_ready_d;
   logic              m_valid_q, m_valid_d;
   logic              wsel_q, wsel_d;
   logic              rsel_q, rsel_d;

   sample_t           sum_lo, diff_lo, sum_hi, diff_hi;
   sample_t           sum_out, diff_out, q_pass, q_neg;

   // First-stage butterflies: (x0, x2) and (x1, x3) with x2/x3 straight from memory
   fft4_bfly u_bfly_lo (
      .a      (x0_q),
      .b      (sample_t'(read_0_0)),
      .sum_c  (sum_lo),
      .diff_c (diff_lo)
   );

   fft4_bfly u_bfly_hi (
      .a      (x1_q),
      .b      (sample_t'(read_0_1)),
      .sum_c  (sum_hi),
      .diff_c (diff_hi)
   );

   // Output-stage butterfly on the bank-H pair (p, q)
   fft4_bfly u_bfly_out (
      .a      (sample_t'(read_1_0)),
      .b      (sample_t'(read_1_1)),
      .sum_c  (sum_out),
      .diff_c (diff_out)
   );

   // 0 +/- q: pass-through and negation of q under the same overflow rule
   fft4_bfly u_bfly_neg (
      .a      ('0),
      .b      (sample_t'(read_1_1)),
      .sum_c  (q_pass),
      .diff_c (q_neg)
   );

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      beat_d  = beat_q;
      sh_l_d  = sh_l_q;
      sh_h_d  = sh_h_q;
      x0_d    = x0_q;
      x1_d    = x1_q;

      case (state_q)
         ST_LOAD: begin
            if (s_valid && s_ready_q) begin
               case (cnt_q)
                  CNT_W'(0): sh_l_d.w00 = s_data;
                  CNT_W'(1): sh_l_d.w01 = s_data;
                  CNT_W'(2): sh_l_d.w10 = s_data;
                  default:   sh_l_d.w11 = s_data;
               endcase
               if (cnt_q == CNT_W'(FRAME_N - 1)) begin
                  state_d = ST_L_SETTLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_L_SETTLE: begin
            state_d = ST_STAGE_A;
         end
         ST_STAGE_A: begin
            x0_d    = read_0_0;
            x1_d    = read_0_1;
            state_d = ST_STAGE_B;
         end
         ST_STAGE_B: begin
            sh_h_d  = '{w00: sum_lo, w01: sum_hi, w10: diff_lo, w11: diff_hi};
            state_d = ST_H_SETTLE;
         end
         ST_H_SETTLE: begin
            beat_d  = '0;
            state_d = ST_OUT;
         end
         ST_OUT: begin
            if (m_valid_q && m_ready) begin
               if (beat_q == CNT_W'(FRAME_N - 1)) begin
                  beat_d  = '0;
                  state_d = ST_LOAD;
               end else begin
                  beat_d = beat_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_LOAD;
            cnt_d   = '0;
            beat_d  = '0;
         end
      endcase

      s_ready_d = (state_d == ST_LOAD);
      m_valid_d = (state_d == ST_OUT);
      wsel_d    = (state_d == ST_H_SETTLE) || (state_d == ST_OUT);
      rsel_d    = 1'b0;
      if (state_d == ST_STAGE_B) begin
         rsel_d = 1'b1;
      end else if (state_d == ST_OUT) begin
         rsel_d = beat_d[0];
      end
      wr_d = wsel_d ? sh_h_d : sh_l_d;
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_LOAD;
         cnt_q     <= '0;
         beat_q    <= '0;
         sh_l_q    <= '0;
         sh_h_q    <= '0;
         wr_q      <= '0;
         x0_q      <= '0;
         x1_q      <= '0;
         s_ready_q <= 1'b0;
         m_valid_q <= 1'b0;
         wsel_q    <= 1'b0;
         rsel_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         beat_q    <= beat_d;
         sh_l_q    <= sh_l_d;
         sh_h_q    <= sh_h_d;
         wr_q      <= wr_d;
         x0_q      <= x0_d;
         x1_q      <= x1_d;
         s_ready_q <= s_ready_d;
         m_valid_q <= m_valid_d;
         wsel_q    <= wsel_d;
         rsel_q    <= rsel_d;
      end
   end

   // Output bin from the bank-H pair currently selected; forced to zero when not valid
   always_comb begin
      m_re = '0;
      m_im = '0;
      if (m_valid_q) begin
         case (beat_q)
            CNT_W'(0): begin
               m_re = sum_out;
            end
            CNT_W'(1): begin
               m_re = read_1_0;
               m_im = q_neg;
            end
            CNT_W'(2): begin
               m_re = diff_out;
            end
            default: begin
               m_re = read_1_0;
               m_im = q_pass;
            end
         endcase
      end
   end

   assign s_ready          = s_ready_q;
   assign m_valid          = m_valid_q;
   assign mem_write_ctrl_s = wsel_q;
   assign mem_read_ctrl_s  = rsel_q;
   assign write_0_0        = wr_q.w00;
   assign write_0_1        = wr_q.w01;
   assign write_1_0        = wr_q.w10;
   assign write_1_1        = wr_q.w11;

endmodule

// File: tb/tb_fft4_mem_seq.sv
// Testbench for fft4_mem_seq: external two-bank memory model, DFT reference model,
// randomized valid/ready timing. Honours FFT4_SAT_EN for the expected overflow rule.
module tb_fft4_mem_seq;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [7:0]        s_data = 8'd0;
   logic              mem_write_ctrl_s, mem_read_ctrl_s;
   logic [7:0]        write_0_0, write_0_1, write_1_0, write_1_1;
   logic [7:0]        read_0_0, read_0_1, read_1_0, read_1_1;
   logic              m_valid;
   logic              m_ready = 1'b0;
   logic signed [7:0] m_re, m_im;

   logic [7:0] mem1_0 = 8'd0, mem1_1 = 8'd0, mem2_0 = 8'd0, mem2_1 = 8'd0;
   logic [7:0] mem3_0 = 8'd0, mem3_1 = 8'd0, mem4_0 = 8'd0, mem4_1 = 8'd0;

   int n_chk  = 0;
   int n_fail = 0;

   fft4_mem_seq dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .s_valid          (s_valid),
      .s_ready          (s_ready),
      .s_data           (s_data),
      .mem_write_ctrl_s (mem_write_ctrl_s),
      .mem_read_ctrl_s  (mem_read_ctrl_s),
      .write_0_0        (write_0_0),
      .write_0_1        (write_0_1),
      .write_1_0        (write_1_0),
      .write_1_1        (write_1_1),
      .read_0_0         (read_0_0),
      .read_0_1         (read_0_1),
      .read_1_0         (read_1_0),
      .read_1_1         (read_1_1),
      .m_valid          (m_valid),
      .m_ready          (m_ready),
      .m_re             (m_re),
      .m_im             (m_im)
   );

   always #5 clk = ~clk;

   // Memory: selected bank written every rising edge, reads combinational
   always @(posedge clk) begin
      if (!mem_write_ctrl_s) begin
         mem1_0 <= write_0_0;
         mem1_1 <= write_0_1;
         mem2_0 <= write_1_0;
         mem2_1 <= write_1_1;
      end else begin
         mem3_0 <= write_0_0;
         mem3_1 <= write_0_1;
         mem4_0 <= write_1_0;
         mem4_1 <= write_1_1;
      end
   end

   assign read_0_0 = mem_read_ctrl_s ? mem2_0 : mem1_0;
   assign read_0_1 = mem_read_ctrl_s ? mem2_1 : mem1_1;
   assign read_1_0 = mem_read_ctrl_s ? mem4_0 : mem3_0;
   assign read_1_1 = mem_read_ctrl_s ? mem4_1 : mem3_1;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // 8-bit result rule applied to an exact integer
   function automatic int fx(input int v);
`ifdef FFT4_SAT_EN
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
`else
      logic signed [7:0] t;
      t = 8'(v);
      return int'(t);
`endif
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_s_ready"}, int'(s_ready), 0);
      chk({tag, "_m_valid"}, int'(m_valid), 0);
      chk({tag, "_wsel"}, int'(mem_write_ctrl_s), 0);
      chk({tag, "_rsel"}, int'(mem_read_ctrl_s), 0);
      chk({tag, "_w00"}, int'(write_0_0), 0);
      chk({tag, "_w01"}, int'(write_0_1), 0);
      chk({tag, "_w10"}, int'(write_1_0), 0);
      chk({tag, "_w11"}, int'(write_1_1), 0);
      chk({tag, "_m_re"}, int'(m_re), 0);
      chk({tag, "_m_im"}, int'(m_im), 0);
   endtask

   // Assert reset at a falling edge, check outputs, release at a falling edge
   task automatic do_reset(input string tag);
      rst_n   = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b0;
      #1;
      check_reset_outputs(tag);
      repeat (2) @(negedge clk);
      check_reset_outputs(tag);
      rst_n = 1'b1;
   endtask

   // Offer the first n samples with random idle cycles; starts and ends at a falling edge
   task automatic send(input int s0, input int s1, input int s2, input int s3, input int n);
      int  smp[4];
      int  k;
      int  g;
      bit  acc;
      smp = '{s0, s1, s2, s3};
      k = 0;
      g = 0;
      while (k < n && g < 200) begin
         s_valid = ($urandom_range(0, 3) != 0);
         s_data  = s_valid ? 8'(smp[k]) : 8'($urandom);
         acc     = s_valid && s_ready;
         @(posedge clk);
         if (acc) k++;
         @(negedge clk);
         g++;
      end
      s_valid = 1'b0;
      chk("samples_accepted", k, n);
   endtask

   // Full frame: send, check latency, collect and check the four bins
   task automatic run_frame(input int s0, input int s1, input int s2, input int s3,
                            input bit rnd_ready, input int stall_beat);
      int a0, a1, a2, a3;
      int er[4];
      int ei[4];
      int lat, stall, g;
      bit hs;
      a0 = fx(s0 + s2);
      a1 = fx(s1 + s3);
      a2 = fx(s0 - s2);
      a3 = fx(s1 - s3);
      er = '{fx(a0 + a1), a2, fx(a0 - a1), a2};
      ei = '{0, fx(-a3), 0, a3};

      send(s0, s1, s2, s3, 4);
      lat = 0;
      while (!m_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("first_valid_latency", lat, 4);

      for (int b = 0; b < 4; b++) begin
         hs    = 1'b0;
         g     = 0;
         stall = (b == stall_beat) ? 3 : 0;
         while (!hs && g < 100) begin
            chk($sformatf("bin%0d_valid", b), int'(m_valid), 1);
            chk($sformatf("bin%0d_re", b), int'(m_re), er[b]);
            chk($sformatf("bin%0d_im", b), int'(m_im), ei[b]);
            chk($sformatf("bin%0d_s_ready", b), int'(s_ready), 0);
            chk($sformatf("bin%0d_rsel", b), int'(mem_read_ctrl_s), b % 2);
            chk($sformatf("bin%0d_wsel", b), int'(mem_write_ctrl_s), 1);
            if (stall > 0) begin
               m_ready = 1'b0;
               stall--;
            end else begin
               m_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            hs = m_ready && m_valid;
            @(posedge clk);
            @(negedge clk);
            g++;
         end
         chk($sformatf("bin%0d_handshake", b), int'(hs), 1);
      end
      m_ready = 1'b0;
      chk("after_frame_m_valid", int'(m_valid), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic signed [7:0] r0, r1, r2, r3;

      @(negedge clk);
      do_reset("reset0");

      run_frame(1, 2, 3, 4, 1'b0, -1);
      run_frame(5, 0, 0, 0, 1'b0, -1);
      run_frame(100, 100, 100, 100, 1'b0, -1);
      run_frame(1, 2, 3, 4, 1'b0, 1);

      send(9, 7, 0, 0, 2);
      do_reset("reset_mid");
      run_frame(1, 2, 3, 4, 1'b0, -1);

      run_frame(1, 2, 3, 4, 1'b0, -1);
      run_frame(5, 0, 0, 0, 1'b0, -1);

      run_frame(-128, 127, 127, -128, 1'b1, -1);
      run_frame(-128, -128, 127, 127, 1'b1, 3);
      run_frame(0, -128, 0, 127, 1'b1, 1);

      for (int i = 0; i < 16; i++) begin
         r0 = 8'($urandom);
         r1 = 8'($urandom);
         r2 = 8'($urandom);
         r3 = 8'($urandom);
         run_frame(int'(r0), int'(r1), int'(r2), int'(r3), 1'b1,
                   int'($urandom_range(0, 5)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fft4_mem_seq.md
FFT4_MEM_SEQ -- requirements
Module: fft4_mem_seq

Interface
REQ-001 clk  in  1  single system clock; all state changes on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous assert, active-low; the only reset.
REQ-003 s_valid  in  1  input sample valid.
REQ-004 s_ready  out  1  input sample accepted on s_valid&&s_ready.
REQ-005 s_data  in  8  input sample, signed two's complement, real.
REQ-006 mem_write_ctrl_s  out  1  memory write bank select; 0 = bank L (mem1/mem2), 1 = bank H (mem3/mem4); the selected bank is written every cycle.
REQ-007 mem_read_ctrl_s  out  1  memory read select; 0 = {mem1_0,mem1_1,mem3_0,mem3_1}, 1 = {mem2_0,mem2_1,mem4_0,mem4_1}.
REQ-008 write_0_0, write_0_1, write_1_0, write_1_1  out  8 each  memory write data.
REQ-009 read_0_0, read_0_1, read_1_0, read_1_1  in  8 each  memory read data, combinational from memory.
REQ-010 m_valid  out  1  output bin valid.
REQ-011 m_ready  in  1  output bin consumed on m_valid&&m_ready.
REQ-012 m_re, m_im  out  8 each  output bin real/imag, signed.

Function
REQ-013 FSM states: LOAD, L_SETTLE, STAGE_A, STAGE_B, H_SETTLE, OUT.
REQ-014 LOAD: s_ready=1; sample k (counter 0..3) stored into shadow L register k; after sample 3 accepted -> L_SETTLE, counter cleared.
REQ-015 write_* always driven from shadow L when mem_write_ctrl_s=0, from shadow H when 1; repeated writes are idempotent.
REQ-016 mem_write_ctrl_s=0 in LOAD, L_SETTLE, STAGE_A, STAGE_B; 1 in H_SETTLE, OUT.
REQ-017 L_SETTLE: one cycle, no action (memory captures bank L).
REQ-018 STAGE_A: mem_read_ctrl_s=0; register x0=read_0_0, x1=read_0_1.
REQ-019 STAGE_B: mem_read_ctrl_s=1; x2=read_0_0, x3=read_0_1; load shadow H {a0,a1,a2,a3} = {x0+x2, x1+x3, x0-x2, x1-x3}.
REQ-020 H_SETTLE: one cycle (memory captures bank H) -> OUT, beat=0.
REQ-021 OUT: m_valid=1; mem_read_ctrl_s = beat[0]; p=read_1_0, q=read_1_1.
REQ-022 Beat 0: X0=(p+q, 0); beat 1: X1=(p, -q); beat 2: X2=(p-q, 0); beat 3: X3=(p, q).
REQ-023 Beat advances only on m_valid&&m_ready; m_re/m_im stable while stalled; beat 3 handshake -> LOAD.
REQ-024 s_valid ignored when s_ready=0; s_ready=0 outside LOAD.
REQ-025 First m_valid asserted exactly 4 cycles after the cycle accepting sample 3.
REQ-026 All arithmetic 8-bit signed; overflow per REQ-031; negation of -128 follows same rule.

Reset
REQ-027 On rst_n low: state=LOAD, counter=0, beat=0, shadow L/H and x regs = 0.
REQ-028 During reset: s_ready=0, m_valid=0, mem_write_ctrl_s=0, mem_read_ctrl_s=0, write_*=0, m_re=m_im=0.
REQ-029 Reset mid-frame discards partial frame; next accepted sample is sample 0.

Configuration
REQ-030 Macro FFT4_SAT_EN selects overflow handling.
REQ-031 Defined: every sum/difference/negation saturates to [-128,127]; undefined: wraps modulo 256.

Structure
REQ-032 Package fft4_pkg: state enum, DATA_W=8, FRAME_N=4, saturating add/sub function.
REQ-033 Sub-module fft4_bfly: 8-bit sum/diff pair with FFT4_SAT_EN handling, used by STAGE_B and OUT.

Verification
REQ-034 Frame {1,2,3,4}, m_ready=1 -> bins (10,0), (-2,2), (-2,0), (-2,-2); first m_valid 4 cycles after 4th accept.
REQ-035 Impulse {5,0,0,0} -> all four bins (5,0).
REQ-036 {100,100,100,100}: wrap build -> X0=(-112,0); FFT4_SAT_EN build -> X0=(127,0).
REQ-037 {1,2,3,4}, m_ready low 3 cycles at beat 1 -> (-2,2) held, s_ready=0 throughout, then remaining bins in order.
REQ-038 rst_n pulsed after 2 samples, then {1,2,3,4} -> same bins as REQ-034; all outputs 0 during reset.
REQ-039 Two back-to-back frames {1,2,3,4},{5,0,0,0} -> second frame's bins unaffected by first.
